// File: rtl/inv_sub_word.sv
// Sequential AES inverse SubWord: one shared InvSbox lookup walks the captured
// word a byte per cycle, with valid/ready handshakes on both sides.
module inv_sub_word #(
    parameter int NUM_BYTES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_valid,
    output logic                        i_ready,
    input  logic [0:NUM_BYTES-1][7:0]   lhs,
    output logic                        o_valid,
    input  logic                        o_ready,
    output logic [0:NUM_BYTES-1][7:0]   o
);

    localparam int CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_BYTES - 1);

    localparam logic [7:0] INV_SBOX [0:255] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[b];
    endfunction

    typedef enum logic [1:0] {
        S_IDLE,
        S_SUB,
        S_DONE
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [CNT_W-1:0]            r_cnt;
    logic [0:NUM_BYTES-1][7:0]   r_word;
    logic [0:NUM_BYTES-1][7:0]   r_o;
    logic [7:0]                  w_sub;
    logic                        w_last;

    // The single lookup instance, shared across all byte positions.
    assign w_sub  = inv_sbox(r_word[r_cnt]);
    assign w_last = (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_valid) w_state_nxt = S_SUB;
            S_SUB:   if (w_last)  w_state_nxt = S_DONE;
            S_DONE:  if (o_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_word <= '0;
            r_o    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_word <= lhs;
                        r_cnt  <= '0;
                    end
                end
                S_SUB: begin
                    r_o[r_cnt] <= w_sub;
                    r_cnt      <= w_last ? '0 : r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Handshake flags depend on state alone, never on the inputs.
    assign i_ready = (r_state == S_IDLE);
    assign o_valid = (r_state == S_DONE);
    assign o       = r_o;

endmodule

// File: tb/tb_inv_sub_word.sv
// Bench for inv_sub_word: reference InvSbox derived from GF(2^8) arithmetic.
module tb_inv_sub_word;

    localparam int NB = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_valid = 1'b0;
    logic              i_ready;
    logic [0:NB-1][7:0] lhs = '0;
    logic              o_valid;
    logic              o_ready = 1'b0;
    logic [0:NB-1][7:0] o;

    int checks = 0;
    int errors = 0;

    logic [7:0] fwd_tbl [0:255];
    logic [7:0] inv_tbl [0:255];

    inv_sub_word #(.NUM_BYTES(NB)) dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_ready(i_ready), .lhs(lhs),
        .o_valid(o_valid), .o_ready(o_ready), .o(o)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // Forward S-box from the field inverse plus affine map, then inverted.
    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] s;
        for (int xv = 0; xv < 256; xv++) begin
            inv = 8'h00;
            for (int yv = 1; yv < 256; yv++)
                if (gmul(8'(xv), 8'(yv)) == 8'h01) inv = 8'(yv);
            s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            fwd_tbl[xv] = s;
            inv_tbl[s]  = 8'(xv);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[31-8*i -: 8] = inv_tbl[w[31-8*i -: 8]];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one word, wait for o_valid, record latency, then acknowledge.
    task automatic do_word(input logic [31:0] w, input bit scramble,
                           output logic [31:0] res, output int lat);
        chk("accept_ready", 32'(i_ready), 32'd1);
        i_valid = 1'b1;
        lhs     = w;
        o_ready = 1'b0;
        tick();
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 20) begin
            if (scramble) lhs = $urandom;
            tick();
            lat++;
        end
        res = o;
        o_ready = 1'b1;
        tick();
        o_ready = 1'b0;
    endtask

    logic [31:0] res;
    logic [31:0] w;
    logic [31:0] held;
    int          lat;
    logic [31:0] exp_q[$];
    logic [31:0] vin  [3];
    logic [31:0] vexp [3];

    initial begin
        build_tables();
        vin[0] = 32'h637C7616; vexp[0] = 32'h00010FFF;
        vin[1] = 32'h00010203; vexp[1] = 32'h52096AD5;
        vin[2] = 32'hFFFFFFFF; vexp[2] = 32'h7D7D7D7D;

        tick();
        tick();
        chk("rst_i_ready", 32'(i_ready), 32'd1);
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o", o, 32'h0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 3; i++) begin
            do_word(vin[i], 1'b0, res, lat);
            chk("vec_latency", 32'(lat), 32'(NB));
            chk("vec_o", res, vexp[i]);
            chk("vec_model", res, ref_word(vin[i]));
        end

        // Reset in the middle of SUB drops the word.
        lhs = 32'h00010203;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("midrst_i_ready", 32'(i_ready), 32'd1);
        chk("midrst_o_valid", 32'(o_valid), 32'd0);
        chk("midrst_o", o, 32'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("midrst_no_valid", 32'(o_valid), 32'd0);
        end

        // Back-pressure: hold o_ready low with i_valid asserted and lhs moving.
        w = $urandom;
        lhs = w;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("bp_latency", 32'(lat), 32'(NB));
        held = o;
        chk("bp_o", held, ref_word(w));
        for (int i = 0; i < 10; i++) begin
            i_valid = 1'b1;
            lhs = $urandom;
            tick();
            chk("bp_o_valid", 32'(o_valid), 32'd1);
            chk("bp_i_ready", 32'(i_ready), 32'd0);
            chk("bp_o_stable", o, held);
        end
        i_valid = 1'b0;
        o_ready = 1'b1;
        tick();
        o_ready = 1'b0;
        chk("bp_release_ready", 32'(i_ready), 32'd1);
        chk("bp_release_valid", 32'(o_valid), 32'd0);

        // Input isolation: lhs changes every SUB cycle.
        do_word(32'h637C7616, 1'b1, res, lat);
        chk("iso_o", res, 32'h00010FFF);

        // Back-to-back stream with both handshakes held high.
        begin
            int sent = 0;
            int got = 0;
            int cyc = 0;
            int last_acc = 0;
            o_ready = 1'b1;
            while (got < 8 && cyc < 200) begin
                if (i_ready && sent < 8) begin
                    i_valid = 1'b1;
                    w = $urandom;
                    lhs = w;
                    exp_q.push_back(ref_word(w));
                    if (sent > 0) chk("stream_gap", 32'(cyc - last_acc), 32'd6);
                    last_acc = cyc;
                    sent++;
                end else if (sent >= 8) begin
                    i_valid = 1'b0;
                end
                if (o_valid && exp_q.size() > 0) begin
                    chk("stream_o", o, exp_q.pop_front());
                    got++;
                end
                tick();
                cyc++;
            end
            chk("stream_count", 32'(got), 32'd8);
            i_valid = 1'b0;
            o_ready = 1'b0;
            tick();
        end

        // Round trip through the forward S-box covers all 256 table entries.
        for (int j = 0; j < 64; j++) begin
            for (int b = 0; b < 4; b++) w[31-8*b -: 8] = fwd_tbl[4*j + b];
            do_word(w, 1'b0, res, lat);
            chk("roundtrip", res, {8'(4*j), 8'(4*j+1), 8'(4*j+2), 8'(4*j+3)});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
